// File: rtl/neuron_datapath.sv
// rtl/neuron_datapath.sv - Q8.8 neuron arithmetic datapath with accumulator, LFSR and multiplier
//
// Executes one instruction per accepted command and holds the result until
// the next completion.
//   instruction word: opcode [35:32], operand A [31:16], operand B [15:0]
//   opcodes: 0 NOP, 1 ADD, 2 SUB, 3 MUL, 4 ACC_CLR, 5 MAC, 6 RELU, 7 HSIG,
//            8 RAND, 9-15 illegal (result 0)
//
// Ports:
//   clock          in   sole clock, rising edge
//   reset          in   asynchronous, active-high
//   instruction_dp in   instruction word, sampled when a command is accepted
//   start_dp       in   command request level, only looked at while idle
//   result_dp      out  registered result, changes only on completion
//   finished_dp    out  1 = idle / result valid, 0 = busy
//
// Build option: DATAPATH_FAST_MUL_EN selects a single-cycle combinational
// multiply for MUL/MAC; left undefined, a 16-iteration serial shift-add
// multiplier is used. Both produce bit-identical results.

module neuron_datapath #(
   parameter int INSTRUCTION_WIDTH = 36,
   parameter int RESULT_WIDTH      = 16
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [INSTRUCTION_WIDTH-1:0] instruction_dp,
   input  logic                         start_dp,
   output logic [RESULT_WIDTH-1:0]      result_dp,
   output logic                         finished_dp
);

   localparam logic [3:0]  OP_NOP     = 4'd0;
   localparam logic [3:0]  OP_ADD     = 4'd1;
   localparam logic [3:0]  OP_SUB     = 4'd2;
   localparam logic [3:0]  OP_MUL     = 4'd3;
   localparam logic [3:0]  OP_ACC_CLR = 4'd4;
   localparam logic [3:0]  OP_MAC     = 4'd5;
   localparam logic [3:0]  OP_RELU    = 4'd6;
   localparam logic [3:0]  OP_HSIG    = 4'd7;
   localparam logic [3:0]  OP_RAND    = 4'd8;
   localparam logic [15:0] LFSR_SEED  = 16'hACE1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      MULT = 2'd2,
      MFIN = 2'd3
   } state_t;

   state_t state, state_nxt;

   // Latched command
   logic [3:0]         op_q;
   logic signed [15:0] a_q;
   logic signed [15:0] b_q;

   // Arithmetic state
   logic signed [31:0] prod_q;
   logic signed [31:0] acc_q;
   logic [15:0]        lfsr_q;
   logic [3:0]         iter_q;
   logic [15:0]        result_q;

   // Incoming instruction fields
   logic [3:0]         op_in;
   logic signed [15:0] a_in;
   logic signed [15:0] b_in;
   logic               is_mul_in;

   assign op_in     = instruction_dp[35:32];
   assign a_in      = instruction_dp[31:16];
   assign b_in      = instruction_dp[15:0];
   assign is_mul_in = (op_in == OP_MUL) || (op_in == OP_MAC);

   assign finished_dp = (state == IDLE);
   assign result_dp   = result_q;

   // Clamp a wide signed value into the 16-bit Q8.8 range.
   function automatic logic [15:0] sat16(input logic signed [32:0] v);
      if (v > 33'sd32767)
         sat16 = 16'h7FFF;
      else if (v < -33'sd32768)
         sat16 = 16'h8000;
      else
         sat16 = v[15:0];
   endfunction

   // Clamp a 33-bit sum into the 32-bit accumulator range: overflow shows up
   // as the two top bits disagreeing.
   function automatic logic [31:0] sat32(input logic signed [32:0] v);
      if (v[32] != v[31])
         sat32 = v[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      else
         sat32 = v[31:0];
   endfunction

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start_dp) begin
               if (is_mul_in) begin
`ifdef DATAPATH_FAST_MUL_EN
                  state_nxt = MFIN;
`else
                  state_nxt = MULT;
`endif
               end else begin
                  state_nxt = EXEC;
               end
            end
         end
         EXEC: state_nxt = IDLE;
         MULT: if (iter_q == 4'd15) state_nxt = MFIN;
         MFIN: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Serial multiplier partial product.
   // A is sign-extended to 32 bits; bit 15 of B carries weight -2^15, so the
   // last iteration subtracts. The true product always fits in 32 signed
   // bits (worst case 0x8000*0x8000 = 0x40000000), so modulo-2^32 sums are
   // exact.
   // ------------------------------------------------------------------
   logic signed [31:0] a_ext;
   logic signed [31:0] a_shift;
   logic signed [31:0] part_prod;

   always_comb begin
      a_ext     = {{16{a_q[15]}}, a_q};
      a_shift   = a_ext <<< iter_q;
      part_prod = 32'sd0;
      if (b_q[iter_q])
         part_prod = (iter_q == 4'd15) ? -a_shift : a_shift;
   end

   // ------------------------------------------------------------------
   // Single-cycle operations
   // ------------------------------------------------------------------
   logic signed [32:0] a33;
   logic signed [32:0] b33;
   logic signed [32:0] sum33;
   logic signed [32:0] diff33;
   logic signed [32:0] hsig33;
   logic [15:0]        exec_result;
   logic [15:0]        lfsr_next;

   assign lfsr_next = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

   always_comb begin
      a33         = {{17{a_q[15]}}, a_q};
      b33         = {{17{b_q[15]}}, b_q};
      sum33       = a33 + b33;
      diff33      = a33 - b33;
      // Hard sigmoid: A/4 + 0.5, clamped to [0, 1.0]
      hsig33      = (a33 >>> 2) + 33'sd128;
      exec_result = 16'h0000;
      case (op_q)
         OP_NOP:     exec_result = 16'h0000;
         OP_ADD:     exec_result = sat16(sum33);
         OP_SUB:     exec_result = sat16(diff33);
         OP_ACC_CLR: exec_result = 16'h0000;
         OP_RELU:    exec_result = a_q[15] ? 16'h0000 : a_q;
         OP_HSIG: begin
            if (hsig33 < 33'sd0)
               exec_result = 16'h0000;
            else if (hsig33 > 33'sd256)
               exec_result = 16'h0100;
            else
               exec_result = hsig33[15:0];
         end
         OP_RAND:    exec_result = lfsr_q;
         default:    exec_result = 16'h0000;
      endcase
   end

   // ------------------------------------------------------------------
   // Multiply finish: MUL rescales the product, MAC folds it into the
   // Q16.16 accumulator first and rescales the new accumulator.
   // ------------------------------------------------------------------
   logic signed [32:0] acc_sum;
   logic signed [31:0] acc_new;
   logic signed [31:0] mul_src;
   logic signed [31:0] mul_shift;
   logic [15:0]        mfin_result;

   always_comb begin
      acc_sum     = {acc_q[31], acc_q} + {prod_q[31], prod_q};
      acc_new     = sat32(acc_sum);
      mul_src     = (op_q == OP_MAC) ? acc_new : prod_q;
      mul_shift   = mul_src >>> 8;
      mfin_result = sat16({mul_shift[31], mul_shift});
   end

   // ------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         op_q     <= OP_NOP;
         a_q      <= 16'sd0;
         b_q      <= 16'sd0;
         prod_q   <= 32'sd0;
         acc_q    <= 32'sd0;
         lfsr_q   <= LFSR_SEED;
         iter_q   <= 4'd0;
         result_q <= 16'h0000;
      end else begin
         case (state)
            IDLE: begin
               if (start_dp) begin
                  op_q   <= op_in;
                  a_q    <= a_in;
                  b_q    <= b_in;
                  iter_q <= 4'd0;
`ifdef DATAPATH_FAST_MUL_EN
                  prod_q <= 32'(a_in) * 32'(b_in);
`else
                  prod_q <= 32'sd0;
`endif
               end
            end
            MULT: begin
               prod_q <= prod_q + part_prod;
               iter_q <= iter_q + 4'd1;
            end
            EXEC: begin
               result_q <= exec_result;
               if (op_q == OP_ACC_CLR)
                  acc_q <= 32'sd0;
               if (op_q == OP_RAND)
                  lfsr_q <= lfsr_next;
            end
            MFIN: begin
               result_q <= mfin_result;
               if (op_q == OP_MAC)
                  acc_q <= acc_new;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_neuron_datapath.sv
// tb/tb_neuron_datapath.sv - directed self-checking bench for neuron_datapath
//
// Drives directed instructions with hand-computed Q8.8 results and checks
// busy/finished timing, result values, hold behaviour and reset.
// Honours DATAPATH_FAST_MUL_EN for the expected multiply latency.

module tb_neuron_datapath;

   logic        clock;
   logic        reset;
   logic [35:0] instruction_dp;
   logic        start_dp;
   logic [15:0] result_dp;
   logic        finished_dp;

   int          total;
   int          bad;
   logic [15:0] last_res;

`ifdef DATAPATH_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = 17;
`endif

   neuron_datapath #(
      .INSTRUCTION_WIDTH(36),
      .RESULT_WIDTH     (16)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .instruction_dp(instruction_dp),
      .start_dp      (start_dp),
      .result_dp     (result_dp),
      .finished_dp   (finished_dp)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h want=0x%0h", tag, obs, exp);
      end
   endtask

   // Issue one command with start_dp held for 'hold' edges, expect completion
   // 'lat' edges after accept with result 'exp', then confirm it stays idle.
   task automatic do_op(input string tag, input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input int hold, input int lat,
                        input logic [15:0] exp);
      int done_at;
      instruction_dp = {op, a, b};
      start_dp       = 1'b1;
      @(posedge clock);
      #1;
      check_val({tag, "_busy"}, {15'd0, finished_dp, result_dp}, {15'd0, 1'b0, last_res});
      done_at = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clock);
         if (k >= hold) start_dp = 1'b0;
         @(posedge clock);
         #1;
         if (finished_dp) begin
            done_at = k;
            break;
         end
      end
      check_val({tag, "_lat"}, done_at, lat);
      check_val(tag, {16'd0, result_dp}, {16'd0, exp});
      last_res = exp;
      @(negedge clock);
      start_dp = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check_val({tag, "_hold"}, {15'd0, finished_dp, result_dp}, {15'd0, 1'b1, exp});
   endtask

   initial begin
      total          = 0;
      bad            = 0;
      last_res       = 16'h0000;
      reset          = 1'b1;
      start_dp       = 1'b0;
      instruction_dp = 36'd0;

      #12;
      check_val("reset_state", {15'd0, finished_dp, result_dp}, {15'd0, 1'b1, 16'h0000});

      // Release reset and request immediately: accepted on the first edge.
      @(negedge clock);
      reset = 1'b0;
      do_op("rand0", 4'd8, 16'h0000, 16'h0000, 1, 1, 16'hACE1);
      do_op("rand1", 4'd8, 16'h0000, 16'h0000, 1, 1, 16'h59C3);

      do_op("add_basic", 4'd1, 16'h0100, 16'h0180, 1, 1, 16'h0280);
      do_op("add_sat",   4'd1, 16'h7F00, 16'h0200, 1, 1, 16'h7FFF);
      do_op("sub_sat",   4'd2, 16'h8000, 16'h0100, 1, 1, 16'h8000);
      do_op("sub_neg",   4'd2, 16'h0100, 16'h0300, 1, 1, 16'hFE00);
      do_op("illegal12", 4'd12, 16'h1234, 16'h5678, 1, 1, 16'h0000);
      do_op("mul_ref",   4'd1, 16'h0001, 16'h0002, 1, 1, 16'h0003);
      do_op("nop",       4'd0, 16'h1111, 16'h2222, 1, 1, 16'h0000);

      do_op("mul_basic", 4'd3, 16'h0180, 16'hFF00, 2, MUL_LAT, 16'hFE80);
      do_op("mul_min",   4'd3, 16'h8000, 16'h8000, 1, MUL_LAT, 16'h7FFF);
      do_op("mul_floor", 4'd3, 16'hFFFF, 16'h0001, 1, MUL_LAT, 16'hFFFF);
      do_op("mul_neg",   4'd3, 16'h8000, 16'h0100, 1, MUL_LAT, 16'h8000);

      do_op("acc_clr",   4'd4, 16'h0000, 16'h0000, 1, 1, 16'h0000);
      do_op("mac0",      4'd5, 16'h0200, 16'h0300, 1, MUL_LAT, 16'h0600);
      do_op("mac1",      4'd5, 16'h0100, 16'h0100, 1, MUL_LAT, 16'h0700);

      do_op("relu_neg",  4'd6, 16'hFF00, 16'h0000, 1, 1, 16'h0000);
      do_op("relu_pos",  4'd6, 16'h0180, 16'h0000, 1, 1, 16'h0180);
      do_op("hsig_zero", 4'd7, 16'h0000, 16'h0000, 1, 1, 16'h0080);
      do_op("hsig_low",  4'd7, 16'hFC00, 16'h0000, 1, 1, 16'h0000);
      do_op("hsig_high", 4'd7, 16'h0400, 16'h0000, 1, 1, 16'h0100);

      // Reset in the middle of a multiply.
      instruction_dp = {4'd3, 16'h0180, 16'h0200};
      start_dp       = 1'b1;
      @(posedge clock);
      #1;
      start_dp = 1'b0;
      repeat (5) @(posedge clock);
      #1;
`ifndef DATAPATH_FAST_MUL_EN
      check_val("mid_mul_busy", {15'd0, finished_dp, result_dp}, {15'd0, 1'b0, 16'h0100});
`endif
      reset = 1'b1;
      #1;
      check_val("async_reset", {15'd0, finished_dp, result_dp}, {15'd0, 1'b1, 16'h0000});
      last_res = 16'h0000;
      @(negedge clock);
      reset = 1'b0;
      repeat (20) @(posedge clock);
      #1;
      check_val("abandoned", {15'd0, finished_dp, result_dp}, {15'd0, 1'b1, 16'h0000});
      do_op("add_after_rst", 4'd1, 16'h0001, 16'h0001, 1, 1, 16'h0002);
      do_op("rand_after_rst", 4'd8, 16'h0000, 16'h0000, 1, 1, 16'hACE1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
